// File: rtl/arith_pkg.sv
// Shared arithmetic-datapath definitions: divider FSM encoding, default
// operand width and the iteration-counter width helper.
package arith_pkg;

  // Default operand/result width for the arithmetic blocks.
  localparam int DEFAULT_WIDTH = 8;

  // Sequential divider control states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

  // Bits needed to hold an iteration count of width-1, never less than one.
  function automatic int cnt_width(input int width);
    int w;
    w = $clog2(width);
    return (w < 1) ? 1 : w;
  endfunction

  localparam int DEFAULT_CNT_WIDTH = cnt_width(DEFAULT_WIDTH);

endpackage : arith_pkg

// File: rtl/div_step.sv
// One restoring-division iteration, purely combinational. The partial
// remainder is shifted left with the next dividend bit entering at the LSB,
// then the divisor is trial-subtracted; a non-negative result is kept and
// yields a quotient bit of 1, otherwise the shifted remainder is restored.
module div_step
  import arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] r,
  input  logic             q_msb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] r_next,
  output logic             q_bit
);

  logic [WIDTH-1:0] r_shift;
  logic [WIDTH:0]   trial;

  // The partial remainder is always below the divisor, so its MSB is zero
  // whenever the shift happens; dropping it loses nothing.
  logic unused_r_msb;
  assign unused_r_msb = r[WIDTH-1];

  assign r_shift = {r[WIDTH-2:0], q_msb};

  // Trial subtract in WIDTH+1 bits; the extra MSB is the borrow.
  assign trial = {1'b0, r_shift} - {1'b0, divisor};

  // Keep the difference when no borrow occurred, otherwise restore.
  always_comb begin
    q_bit  = ~trial[WIDTH];
    r_next = trial[WIDTH] ? r_shift : trial[WIDTH-1:0];
  end

endmodule : div_step

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
// start/busy/done handshake; results are held until the next operation
// completes. Division by zero short-circuits to DONE with all-ones quotient,
// the dividend as remainder and div_by_zero set.
module seq_divider
  import arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = cnt_width(WIDTH);

  div_state_t state, state_next;

  // Working registers: partial remainder, dividend/quotient shift register,
  // latched divisor and iteration counter.
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvs_q;
  logic [CW-1:0]    cnt_q;

  logic [WIDTH-1:0] step_r;
  logic             step_q_bit;
  logic [WIDTH-1:0] quo_shift;

  logic accept;
  logic accept_zero;
  logic last_iter;

  // Start is only honoured in IDLE; a zero divisor bypasses CALC.
  assign accept      = (state == IDLE) && start;
  assign accept_zero = accept && (divisor == '0);
  assign last_iter   = (state == CALC) && (cnt_q == '0);

  div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .r       (rem_q),
    .q_msb   (quo_q[WIDTH-1]),
    .divisor (dvs_q),
    .r_next  (step_r),
    .q_bit   (step_q_bit)
  );

  // Dividend bits leave at the top while quotient bits enter at the bottom.
  assign quo_shift = {quo_q[WIDTH-2:0], step_q_bit};

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  // NOTE: state_next gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = accept_zero ? DONE : CALC;
        end
      end
      CALC: begin
        if (cnt_q == '0) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Status outputs decode directly from the state, so they can never overlap.
  always_comb begin
    busy = (state == CALC);
    done = (state == DONE);
  end

  // Iteration datapath: load on accept, one restoring step per CALC cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
    end else if (accept && !accept_zero) begin
      rem_q <= '0;
      quo_q <= dividend;
      dvs_q <= divisor;
      cnt_q <= CW'(WIDTH - 1);
    end else if (state == CALC) begin
      rem_q <= step_r;
      quo_q <= quo_shift;
      if (cnt_q != '0) begin
        cnt_q <= cnt_q - CW'(1);
      end
    end
  end

  // Result registers change only on entry to DONE and hold otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept_zero) begin
      quotient    <= '1;
      remainder   <= dividend;
      div_by_zero <= 1'b1;
    end else if (last_iter) begin
      quotient    <= quo_shift;
      remainder   <= step_r;
      div_by_zero <= 1'b0;
    end
  end

endmodule : seq_divider

// File: tb/tb_seq_divider.sv
// Directed and swept checks of seq_divider at WIDTH 8, 4 and 16.
module tb_seq_divider;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  // WIDTH=8 instance
  logic       start8;
  logic [7:0] dividend8, divisor8, quotient8, remainder8;
  logic       busy8, done8, dbz8;

  // WIDTH=4 instance
  logic       start4;
  logic [3:0] dividend4, divisor4, quotient4, remainder4;
  logic       busy4, done4, dbz4;

  // WIDTH=16 instance
  logic        start16;
  logic [15:0] dividend16, divisor16, quotient16, remainder16;
  logic        busy16, done16, dbz16;

  int checks = 0;
  int errors = 0;

  seq_divider #(.WIDTH(8)) dut8 (
    .clk         (clk),
    .rst         (rst),
    .start       (start8),
    .dividend    (dividend8),
    .divisor     (divisor8),
    .busy        (busy8),
    .done        (done8),
    .quotient    (quotient8),
    .remainder   (remainder8),
    .div_by_zero (dbz8)
  );

  seq_divider #(.WIDTH(4)) dut4 (
    .clk         (clk),
    .rst         (rst),
    .start       (start4),
    .dividend    (dividend4),
    .divisor     (divisor4),
    .busy        (busy4),
    .done        (done4),
    .quotient    (quotient4),
    .remainder   (remainder4),
    .div_by_zero (dbz4)
  );

  seq_divider #(.WIDTH(16)) dut16 (
    .clk         (clk),
    .rst         (rst),
    .start       (start16),
    .dividend    (dividend16),
    .divisor     (divisor16),
    .busy        (busy16),
    .done        (done16),
    .quotient    (quotient16),
    .remainder   (remainder16),
    .div_by_zero (dbz16)
  );

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one cycle; returns in the cycle after E0.
  task automatic issue8(input logic [7:0] a, input logic [7:0] b);
    dividend8 = a;
    divisor8  = b;
    start8    = 1'b1;
    step();
    start8    = 1'b0;
  endtask

  // Wait for done; lat counts cycles with the current cycle as 1.
  task automatic wait8(output int lat, output int busy_cnt, output bit timed_out);
    lat      = 1;
    busy_cnt = 0;
    while (!done8 && lat < 40) begin
      if (busy8) busy_cnt++;
      step();
      lat++;
    end
    timed_out = !done8;
  endtask

  // Count done and busy cycles over a quiet window.
  task automatic watch8(input int n, output int n_done, output int n_busy);
    n_done = 0;
    n_busy = 0;
    for (int i = 0; i < n; i++) begin
      if (done8) n_done++;
      if (busy8) n_busy++;
      step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start8 = 1'b0; dividend8 = '0; divisor8 = '0;
    start4 = 1'b0; dividend4 = '0; divisor4 = '0;
    start16 = 1'b0; dividend16 = '0; divisor16 = '0;
    step();
    step();
    checks++;
    if ({busy8, done8, dbz8} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: got busy=%0b done=%0b dbz=%0b expected all 0", busy8, done8, dbz8);
    end
    checks++;
    if ({quotient8, remainder8} !== 16'h0000) begin
      errors++;
      $display("FAIL reset_results: got q=%0d r=%0d expected 0 0", quotient8, remainder8);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    int lat, bc;
    bit to;
    issue8(8'd200, 8'd7);
    wait8(lat, bc, to);
    checks++;
    if (to || lat !== 9) begin
      errors++;
      $display("FAIL basic_latency: got %0d cycles (timeout=%0b) expected 9", lat, to);
    end
    checks++;
    if (bc !== 8) begin
      errors++;
      $display("FAIL basic_busy_cycles: got %0d expected 8", bc);
    end
    checks++;
    if (busy8 !== 1'b0) begin
      errors++;
      $display("FAIL basic_busy_with_done: got busy=%0b expected 0", busy8);
    end
    checks++;
    if (quotient8 !== 8'd28 || remainder8 !== 8'd4 || dbz8 !== 1'b0) begin
      errors++;
      $display("FAIL basic_200_7: got q=%0d r=%0d dbz=%0b expected q=28 r=4 dbz=0",
               quotient8, remainder8, dbz8);
    end
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    bit to;
    step();
    issue8(8'd255, 8'd1);
    wait8(lat, bc, to);
    checks++;
    if (to || lat !== 9 || quotient8 !== 8'd255 || remainder8 !== 8'd0) begin
      errors++;
      $display("FAIL b2b_first: got lat=%0d q=%0d r=%0d expected lat=9 q=255 r=0",
               lat, quotient8, remainder8);
    end
    // Next start in the first IDLE cycle gives the minimum issue interval.
    step();
    issue8(8'd5, 8'd9);
    checks++;
    if (busy8 !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept: got busy=%0b expected 1", busy8);
    end
    step();
    step();
    checks++;
    if (quotient8 !== 8'd255 || remainder8 !== 8'd0) begin
      errors++;
      $display("FAIL b2b_hold_in_calc: got q=%0d r=%0d expected q=255 r=0", quotient8, remainder8);
    end
    wait8(lat, bc, to);
    checks++;
    if (to || lat !== 7 || quotient8 !== 8'd0 || remainder8 !== 8'd5) begin
      errors++;
      $display("FAIL b2b_second: got lat=%0d q=%0d r=%0d expected lat=7 q=0 r=5",
               lat, quotient8, remainder8);
    end
    step();
    step();
    step();
    checks++;
    if (quotient8 !== 8'd0 || remainder8 !== 8'd5 || done8 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_hold_idle: got q=%0d r=%0d done=%0b expected q=0 r=5 done=0",
               quotient8, remainder8, done8);
    end
  endtask

  task automatic test_div_zero();
    int lat, bc;
    bit to;
    step();
    issue8(8'd100, 8'd0);
    wait8(lat, bc, to);
    checks++;
    if (to || lat !== 1 || bc !== 0 || busy8 !== 1'b0) begin
      errors++;
      $display("FAIL dbz_timing: got lat=%0d busy_cycles=%0d busy=%0b expected lat=1 busy_cycles=0 busy=0",
               lat, bc, busy8);
    end
    checks++;
    if (quotient8 !== 8'd255 || remainder8 !== 8'd100 || dbz8 !== 1'b1) begin
      errors++;
      $display("FAIL dbz_result: got q=%0d r=%0d dbz=%0b expected q=255 r=100 dbz=1",
               quotient8, remainder8, dbz8);
    end
    step();
    checks++;
    if (done8 !== 1'b0 || dbz8 !== 1'b1 || busy8 !== 1'b0) begin
      errors++;
      $display("FAIL dbz_hold: got done=%0b dbz=%0b busy=%0b expected done=0 dbz=1 busy=0",
               done8, dbz8, busy8);
    end
  endtask

  task automatic test_ignored_start();
    int lat, bc, nd, nb;
    bit to;
    step();
    issue8(8'd200, 8'd7);
    step();
    step();
    dividend8 = 8'd50;
    divisor8  = 8'd3;
    start8    = 1'b1;
    step();
    start8    = 1'b0;
    wait8(lat, bc, to);
    checks++;
    if (to || lat !== 6) begin
      errors++;
      $display("FAIL ignore_latency: got %0d remaining cycles (timeout=%0b) expected 6", lat, to);
    end
    checks++;
    if (quotient8 !== 8'd28 || remainder8 !== 8'd4 || dbz8 !== 1'b0) begin
      errors++;
      $display("FAIL ignore_result: got q=%0d r=%0d dbz=%0b expected q=28 r=4 dbz=0",
               quotient8, remainder8, dbz8);
    end
    step();
    watch8(15, nd, nb);
    checks++;
    if (nd !== 0 || nb !== 0) begin
      errors++;
      $display("FAIL ignore_no_second: got done_cycles=%0d busy_cycles=%0d expected 0 0", nd, nb);
    end
  endtask

  task automatic test_reset_mid();
    int lat, bc, nd, nb;
    bit to;
    issue8(8'd200, 8'd7);
    step();
    step();
    #2 rst = 1'b1;
    #1;
    checks++;
    if (busy8 !== 1'b0 || done8 !== 1'b0 || dbz8 !== 1'b0) begin
      errors++;
      $display("FAIL midrst_flags: got busy=%0b done=%0b dbz=%0b expected 0 0 0", busy8, done8, dbz8);
    end
    checks++;
    if (quotient8 !== 8'd0 || remainder8 !== 8'd0) begin
      errors++;
      $display("FAIL midrst_results: got q=%0d r=%0d expected 0 0", quotient8, remainder8);
    end
    step();
    step();
    rst = 1'b0;
    watch8(15, nd, nb);
    checks++;
    if (nd !== 0 || nb !== 0) begin
      errors++;
      $display("FAIL midrst_no_done: got done_cycles=%0d busy_cycles=%0d expected 0 0", nd, nb);
    end
    issue8(8'd9, 8'd2);
    wait8(lat, bc, to);
    checks++;
    if (to || lat !== 9 || quotient8 !== 8'd4 || remainder8 !== 8'd1) begin
      errors++;
      $display("FAIL midrst_next_9_2: got lat=%0d q=%0d r=%0d expected lat=9 q=4 r=1",
               lat, quotient8, remainder8);
    end
  endtask

  task automatic test_sweep_w4();
    int lat;
    logic [3:0] eq, er;
    logic       ez;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        step();
        dividend4 = 4'(a);
        divisor4  = 4'(b);
        start4    = 1'b1;
        step();
        start4    = 1'b0;
        lat = 1;
        while (!done4 && lat < 20) begin
          step();
          lat++;
        end
        ez = (b == 0);
        eq = ez ? 4'hF : 4'(a / b);
        er = ez ? 4'(a) : 4'(a % b);
        checks++;
        if (!done4 || lat !== (ez ? 1 : 5) || quotient4 !== eq || remainder4 !== er || dbz4 !== ez) begin
          errors++;
          $display("FAIL w4_%0d_div_%0d: got lat=%0d q=%0d r=%0d dbz=%0b expected lat=%0d q=%0d r=%0d dbz=%0b",
                   a, b, lat, quotient4, remainder4, dbz4, ez ? 1 : 5, eq, er, ez);
        end
      end
    end
  endtask

  task automatic test_sweep_w16();
    int lat;
    logic [15:0] a, b, eq, er;
    logic        ez;
    for (int i = 0; i < 300; i++) begin
      case (i)
        0: begin a = 16'hFFFF; b = 16'h0001; end
        1: begin a = 16'hFFFF; b = 16'hFFFF; end
        2: begin a = 16'h1234; b = 16'h0000; end
        3: begin a = 16'h0003; b = 16'hFFFE; end
        4: begin a = 16'hFFFE; b = 16'h8001; end
        default: begin
          a = 16'($urandom);
          b = (i % 4 == 0) ? 16'($urandom_range(0, 15)) : 16'($urandom);
        end
      endcase
      step();
      dividend16 = a;
      divisor16  = b;
      start16    = 1'b1;
      step();
      start16    = 1'b0;
      lat = 1;
      while (!done16 && lat < 40) begin
        step();
        lat++;
      end
      ez = (b == 16'd0);
      eq = ez ? 16'hFFFF : a / b;
      er = ez ? a : a % b;
      checks++;
      if (!done16 || lat !== (ez ? 1 : 17) || quotient16 !== eq || remainder16 !== er || dbz16 !== ez) begin
        errors++;
        $display("FAIL w16_%0d_div_%0d: got lat=%0d q=%0d r=%0d dbz=%0b expected lat=%0d q=%0d r=%0d dbz=%0b",
                 a, b, lat, quotient16, remainder16, dbz16, ez ? 1 : 17, eq, er, ez);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_div_zero();
    test_ignored_start();
    test_reset_mid();
    test_sweep_w4();
    test_sweep_w16();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time bound so a stuck handshake can never hang the run.
  initial begin
    #2ms;
    $display("FAIL watchdog: simulation exceeded time limit, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule : tb_seq_divider
